// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: transmit scheduler in front of usb_tx; define USB_TX_CTRL_IPG_EN for an inter-packet gap
module usb_tx_ctrl #(
  parameter int MAX_SIZE       = 64,
  parameter int SE0_MIN        = 8,
  parameter int TIMEOUT_CYCLES = 6000
`ifdef USB_TX_CTRL_IPG_EN
  , parameter int IPG_CYCLES   = 16
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ack_req,
  input  logic       nak_req,
  input  logic       data_req,
  input  logic [6:0] data_size,
  input  logic       get_tx_packet_data,
  input  logic       dplus_out_mon,
  input  logic       dminus_out_mon,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_size,
  output logic       fifo_pop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam logic [1:0] PKT_IDLE = 2'b00;
  localparam logic [1:0] PKT_DATA = 2'b01;
  localparam logic [1:0] PKT_NAK  = 2'b10;
  localparam logic [1:0] PKT_ACK  = 2'b11;
  localparam int SW = $clog2(SE0_MIN + 1);

`ifdef USB_TX_CTRL_IPG_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SE0, WAIT_J, DONE, GAP} state_t;
  localparam state_t AFTER_PKT = GAP;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SE0, WAIT_J, DONE} state_t;
  localparam state_t AFTER_PKT = IDLE;
`endif

  state_t        state_q, state_d;
  logic          ack_q, ack_d, nak_q, nak_d, dat_q, dat_d, err_q, err_d;
  logic [6:0]    dsize_q, dsize_d, size_q, size_d, pop_q, pop_d;
  logic [1:0]    pkt_q, pkt_d;
  logic [SW-1:0] se0_q, se0_d;
  logic [12:0]   tmo_q, tmo_d;
  logic          se0, line_j, in_flight, bad_size, timeout;

  assign se0       = !dplus_out_mon && !dminus_out_mon;
  assign line_j    = dplus_out_mon && !dminus_out_mon;
  assign in_flight = (state_q == WAIT_SE0) || (state_q == WAIT_J);
  assign bad_size  = data_req && (data_size > 7'(MAX_SIZE));
  assign timeout   = in_flight && (tmo_q == 13'(TIMEOUT_CYCLES - 1));

  assign tx_packet      = (state_q == ISSUE) ? pkt_q : PKT_IDLE;
  assign tx_packet_size = size_q;
  assign fifo_pop       = get_tx_packet_data && in_flight && (pkt_q == PKT_DATA) && (pop_q < size_q);
  assign tx_busy        = ack_q || nak_q || dat_q || (state_q != IDLE);
  assign tx_done        = (state_q == DONE);
  assign tx_error       = err_q;

  // Request latching, arbitration, EOP detection and timeout; a timeout overrides the packet FSM
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    nak_d   = nak_q;
    dat_d   = dat_q;
    dsize_d = dsize_q;
    size_d  = size_q;
    pop_d   = pop_q;
    pkt_d   = pkt_q;
    se0_d   = se0_q;
    tmo_d   = tmo_q;
    err_d   = bad_size || (ack_req && nak_req);
    if (ack_req && !ack_q) ack_d = 1'b1;
    if (nak_req && !ack_req && !nak_q) nak_d = 1'b1;
    if (data_req && !bad_size && !dat_q) begin
      dat_d   = 1'b1;
      dsize_d = data_size;
    end
    if (fifo_pop) pop_d = pop_q + 7'd1;
    case (state_q)
      IDLE: if (ack_q || nak_q || dat_q) begin
        state_d = ISSUE;
        pkt_d   = ack_q ? PKT_ACK : nak_q ? PKT_NAK : PKT_DATA;
        size_d  = (ack_q || nak_q) ? 7'd0 : dsize_q;
        ack_d   = ack_q ? 1'b0 : ack_d;
        nak_d   = (!ack_q && nak_q) ? 1'b0 : nak_d;
        dat_d   = (!ack_q && !nak_q) ? 1'b0 : dat_d;
        tmo_d   = '0;
      end
      ISSUE: begin
        state_d = WAIT_SE0;
        pop_d   = '0;
        se0_d   = '0;
        tmo_d   = tmo_q + 13'd1;
      end
      WAIT_SE0: begin
        se0_d   = se0 ? se0_q + 1'b1 : '0;
        state_d = (se0 && se0_q == SW'(SE0_MIN - 1)) ? WAIT_J : WAIT_SE0;
        tmo_d   = tmo_q + 13'd1;
      end
      WAIT_J: begin
        state_d = line_j ? DONE : WAIT_J;
        tmo_d   = tmo_q + 13'd1;
      end
      DONE: begin
        state_d = AFTER_PKT;
        size_d  = '0;
        tmo_d   = '0;
      end
`ifdef USB_TX_CTRL_IPG_EN
      GAP: begin
        state_d = (tmo_q == 13'(IPG_CYCLES - 1)) ? IDLE : GAP;
        tmo_d   = tmo_q + 13'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = AFTER_PKT;
      err_d   = 1'b1;
      size_d  = '0;
      tmo_d   = '0;
    end
  end

  // State and pending-request registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      nak_q   <= 1'b0;
      dat_q   <= 1'b0;
      err_q   <= 1'b0;
      dsize_q <= '0;
      size_q  <= '0;
      pop_q   <= '0;
      pkt_q   <= PKT_IDLE;
      se0_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      nak_q   <= nak_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      dsize_q <= dsize_d;
      size_q  <= size_d;
      pop_q   <= pop_d;
      pkt_q   <= pkt_d;
      se0_q   <= se0_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: directed and randomized checks of usb_tx_ctrl against a request-level model
`timescale 1ns/1ps
module tb_usb_tx_ctrl;
  localparam int TIMEOUT = 6000;
  localparam int IPG     = 16;
  localparam int MAXSZ   = 64;

  logic       clk = 0, n_rst = 0;
  logic       ack_req = 0, nak_req = 0, data_req = 0, get_tx_packet_data = 0;
  logic       dplus_out_mon = 1, dminus_out_mon = 0;
  logic [6:0] data_size = 0;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_size;
  logic       fifo_pop, tx_busy, tx_done, tx_error;

  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, pop_cnt = 0;

  usb_tx_ctrl dut (
    .clk(clk), .n_rst(n_rst), .ack_req(ack_req), .nak_req(nak_req), .data_req(data_req),
    .data_size(data_size), .get_tx_packet_data(get_tx_packet_data),
    .dplus_out_mon(dplus_out_mon), .dminus_out_mon(dminus_out_mon),
    .tx_packet(tx_packet), .tx_packet_size(tx_packet_size), .fifo_pop(fifo_pop),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #3;
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (fifo_pop) pop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic req(input logic a, input logic n, input logic d, input logic [6:0] sz);
    @(negedge clk);
    ack_req = a; nak_req = n; data_req = d; data_size = sz;
    @(negedge clk);
    ack_req = 0; nak_req = 0; data_req = 0;
  endtask

  task automatic line(input logic p, input logic m, input logic g);
    @(negedge clk);
    dplus_out_mon = p; dminus_out_mon = m; get_tx_packet_data = g;
  endtask

  task automatic expect_issue(input string tag, input logic [1:0] code, input logic [6:0] sz,
                              output int lat, output longint t);
    lat = 0;
    while (tx_packet == 2'b00 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    t = $time;
    chk({tag, "_code"}, tx_packet, code);
    chk({tag, "_size"}, tx_packet_size, sz);
    @(negedge clk);
    chk({tag, "_one_cycle"}, tx_packet, 0);
  endtask

  task automatic drive_pkt(input int strobes, input int glitch, input int se0_len);
    logic b;
    for (int i = 0; i < 6; i++) begin b = 1'($urandom_range(0, 1)); line(b, !b, 0); end
    for (int s = 0; s < strobes; s++) begin
      b = 1'($urandom_range(0, 1)); line(b, !b, 1);
      b = 1'($urandom_range(0, 1)); line(b, !b, 0);
    end
    if (glitch > 0) begin
      repeat (glitch) line(0, 0, 0);
      line(0, 1, 0);
    end
    repeat (se0_len) line(0, 0, 0);
    line(1, 0, 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!tx_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, tx_done, 1);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_packet != 2'b00) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic gap_chk(input string tag, input int lat);
`ifdef USB_TX_CTRL_IPG_EN
    chk(tag, lat >= IPG, 1);
`else
    chk(tag, lat, 2);
`endif
  endtask

  initial begin
    int lat, d0, p0, e0, str, sz, exp_err;
    longint t0;
    logic a, n, d;
    logic [1:0] ecode[$];
    int esize[$];

    repeat (2) @(negedge clk);
    chk("reset_outputs", {tx_packet, tx_packet_size, fifo_pop, tx_busy, tx_done, tx_error}, 0);
    n_rst = 1;

    d0 = done_cnt; p0 = pop_cnt;
    req(1, 0, 0, 0);
    chk("ack_pending_busy", tx_busy, 1);
    chk("ack_pending_idle", tx_packet, 0);
    expect_issue("ack", 2'b11, 0, lat, t0);
    chk("ack_latency", lat, 1);
    drive_pkt(3, 0, 16);
    wait_done("ack");
    repeat (3) @(negedge clk);
    chk("ack_done_count", done_cnt - d0, 1);
    chk("ack_no_pops", pop_cnt - p0, 0);
    chk("ack_busy_end", tx_busy, 0);

    req(0, 1, 1, 2);
    expect_issue("nak_first", 2'b10, 0, lat, t0);
    chk("nak_latency", lat, 1);
    drive_pkt(0, 0, 16);
    wait_done("nak_first");
    expect_issue("data2", 2'b01, 2, lat, t0);
    gap_chk("data2_gap", lat);
    p0 = pop_cnt;
    drive_pkt(3, 0, 16);
    wait_done("data2");
    repeat (3) @(negedge clk);
    chk("data2_pops", pop_cnt - p0, 2);
    chk("data2_busy_end", tx_busy, 0);

    e0 = err_cnt;
    req(0, 0, 1, 65);
    chk("oversize_err", tx_error, 1);
    chk("oversize_busy", tx_busy, 0);
    quiet("oversize_quiet", 6);
    chk("oversize_busy_later", tx_busy, 0);
    chk("oversize_err_count", err_cnt - e0, 1);

    req(1, 1, 0, 0);
    chk("acknak_err", tx_error, 1);
    expect_issue("acknak_ack", 2'b11, 0, lat, t0);
    drive_pkt(1, 0, 9);
    wait_done("acknak_ack");
    quiet("acknak_nak_dropped", 30);
    chk("acknak_busy_end", tx_busy, 0);

    @(negedge clk);
    ack_req = 1; data_req = 1; data_size = 3;
    @(negedge clk);
    ack_req = 0; data_req = 1; data_size = 9;
    @(negedge clk);
    data_req = 0;
    chk("dup_ack_code", tx_packet, 2'b11);
    @(negedge clk);
    chk("dup_ack_one_cycle", tx_packet, 0);
    drive_pkt(0, 3, 8);
    wait_done("dup_ack");
    expect_issue("dup_data", 2'b01, 3, lat, t0);
    drive_pkt(1, 0, 8);
    wait_done("dup_data");
    quiet("dup_ignored", 30);

    d0 = done_cnt; e0 = err_cnt;
    req(1, 0, 0, 0);
    expect_issue("to_ack", 2'b11, 0, lat, t0);
    req(0, 1, 0, 0);
    lat = 0;
    while (!tx_error && lat < TIMEOUT + 100) begin
      @(negedge clk);
      lat++;
    end
    chk("to_cycles", int'(($time - t0) / 10), TIMEOUT);
    chk("to_keeps_pending", tx_busy, 1);
    expect_issue("to_nak", 2'b10, 0, lat, t0);
`ifndef USB_TX_CTRL_IPG_EN
    chk("to_nak_latency", lat, 1);
`endif
    drive_pkt(0, 0, 8);
    wait_done("to_nak");
    repeat (3) @(negedge clk);
    chk("to_done_count", done_cnt - d0, 1);
    chk("to_err_count", err_cnt - e0, 1);

    d0 = done_cnt;
    req(1, 0, 1, 5);
    expect_issue("rst_ack", 2'b11, 0, lat, t0);
    repeat (4) line(0, 0, 0);
    @(negedge clk);
    n_rst = 0;
    #1;
    chk("rst_mid_outputs", {tx_packet, tx_packet_size, fifo_pop, tx_busy, tx_done, tx_error}, 0);
    @(negedge clk);
    n_rst = 1;
    line(1, 0, 0);
    quiet("rst_pending_lost", 20);
    chk("rst_busy", tx_busy, 0);
    chk("rst_no_done", done_cnt - d0, 0);

    for (int it = 0; it < 25; it++) begin
      a = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, 5));
      ecode.delete();
      esize.delete();
      if (a) begin ecode.push_back(2'b11); esize.push_back(0); end
      if (n && !a) begin ecode.push_back(2'b10); esize.push_back(0); end
      if (d && sz <= MAXSZ) begin ecode.push_back(2'b01); esize.push_back(sz); end
      exp_err = ((a && n) || (d && sz > MAXSZ)) ? 1 : 0;
      e0 = err_cnt;
      req(a, n, d, 7'(sz));
      chk("rnd_err_pulse", tx_error, exp_err);
      for (int k = 0; k < ecode.size(); k++) begin
        expect_issue("rnd", ecode[k], 7'(esize[k]), lat, t0);
        if (k == 0) chk("rnd_first_latency", lat, 1);
        else gap_chk("rnd_next_latency", lat);
        str = $urandom_range(0, 6);
        p0 = pop_cnt;
        drive_pkt(str, $urandom_range(0, 7), $urandom_range(8, 14));
        wait_done("rnd");
        chk("rnd_pops", pop_cnt - p0, (ecode[k] == 2'b01) ? ((str < esize[k]) ? str : esize[k]) : 0);
      end
      quiet("rnd_quiet", 20);
      chk("rnd_busy_end", tx_busy, 0);
      chk("rnd_err_count", err_cnt - e0, exp_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
